// File: rtl/fht_stage_ctrl_if.sv
// Bus between the FHT stage sequencer and its consumers: the bank RAMs,
// the twiddle ROM, the butterfly block and the host that starts a transform.
interface fht_stage_ctrl_if #(
    parameter int A_BIT   = 8,
    parameter int SEC_BIT = 4,
    parameter int ST_BIT  = 4
);
    logic               start;
    logic               busy;
    logic               done;
    logic [A_BIT-1:0]   rd_addr;
    logic [A_BIT-1:0]   wr_addr;
    logic               we;
    logic [A_BIT-2:0]   w_addr;
    logic               st_zero;
    logic [SEC_BIT-1:0] sector;
    logic               st_last;
    logic               second_part_subsector;
    logic [ST_BIT-1:0]  stage;

    // Sequencer side: drives addresses and strobes, receives start.
    modport master (
        input  start,
        output busy, done, rd_addr, wr_addr, we, w_addr,
               st_zero, sector, st_last, second_part_subsector, stage
    );

    // Host / consumer side.
    modport slave (
        output start,
        input  busy, done, rd_addr, wr_addr, we, w_addr,
               st_zero, sector, st_last, second_part_subsector, stage
    );
endinterface

// File: rtl/fht_stage_ctrl.sv
// Stage sequencer for the radix-2 FHT. Walks NST = A_BIT+2 stages; each stage
// reads every bank address once, then drains LAT cycles so the butterfly
// writes of this stage land before the next stage reads. Control strobes are
// delayed to line up with the read data or the butterfly output register.
module fht_stage_ctrl #(
    parameter int A_BIT   = 8,
    parameter int SEC_BIT = 4,
    parameter int ST_BIT  = 4,
    parameter int LAT     = 5
) (
    input  logic              iCLK,
    input  logic              iRESET,
    fht_stage_ctrl_if.master  bus
);
    localparam int DEPTH  = 1 << A_BIT;
    localparam int NST    = A_BIT + 2;
    localparam int DR_BIT = $clog2(LAT);

    localparam logic [A_BIT-1:0]  RD_LAST     = A_BIT'(DEPTH - 1);
    localparam logic [ST_BIT-1:0] ST_LAST_IDX = ST_BIT'(NST - 1);
    localparam logic [ST_BIT-1:0] M_MAX       = ST_BIT'(A_BIT - 1);
    localparam logic [DR_BIT-1:0] DR_LAST     = DR_BIT'(LAT - 1);

    typedef enum logic [1:0] {IDLE, READ, DRAIN, FIN} state_t;

    state_t             state;
    logic [A_BIT-1:0]   rd_cnt;
    logic [ST_BIT-1:0]  stage;
    logic [DR_BIT-1:0]  drain_cnt;
    logic               busy_q;
    logic               done_q;

    logic               rd_valid;
    logic [SEC_BIT-1:0] sec_raw;
    logic [A_BIT-2:0]   wi;
    logic [ST_BIT-1:0]  m;
    logic [A_BIT-2:0]   w_next;

    logic [LAT-1:0]     we_sr;
    logic [A_BIT-1:0]   wa_sr [LAT];
    logic [LAT-2:0]     last_sr;
    logic [LAT-2:0]     part_sr;
    logic               st_zero_q;
    logic [SEC_BIT-1:0] sector_q;
    logic [A_BIT-2:0]   w_addr_q;

    // Stage/read/drain sequencing with registered busy and done.
    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            state     <= IDLE;
            rd_cnt    <= '0;
            stage     <= '0;
            drain_cnt <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments only; later ones in this block override the default below.
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state  <= READ;
                        stage  <= '0;
                        rd_cnt <= '0;
                        busy_q <= 1'b1;
                    end
                end
                READ: begin
                    if (rd_cnt == RD_LAST) begin
                        state     <= DRAIN;
                        drain_cnt <= '0;
                    end else begin
                        rd_cnt <= rd_cnt + 1'b1;
                    end
                end
                DRAIN: begin
                    if (drain_cnt == DR_LAST) begin
                        if (stage == ST_LAST_IDX) begin
                            state  <= FIN;
                            done_q <= 1'b1;
                        end else begin
                            stage  <= stage + 1'b1;
                            rd_cnt <= '0;
                            state  <= READ;
                        end
                    end else begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end
                FIN: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign rd_valid = (state == READ);
    assign sec_raw  = rd_cnt[A_BIT-1 -: SEC_BIT];
    assign wi       = rd_cnt[A_BIT-1:1];

    // Twiddle index for the current read: coarser spacing in early stages.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        m = stage;
        if (stage > M_MAX) m = M_MAX;
        w_next = wi << (M_MAX - m);
    end

    // Alignment delay lines: write path (LAT), butterfly strobes (LAT-1), read-data strobes (1).
    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            we_sr     <= '0;
            last_sr   <= '0;
            part_sr   <= '0;
            st_zero_q <= 1'b0;
            sector_q  <= '0;
            w_addr_q  <= '0;
            // NOTE: the address delay line is cleared on reset so no stale write address survives an abort.
            for (int i = 0; i < LAT; i++) wa_sr[i] <= '0;
        end else begin
            we_sr      <= {we_sr[LAT-2:0], rd_valid};
            wa_sr[0]   <= rd_cnt;
            for (int i = 1; i < LAT; i++) wa_sr[i] <= wa_sr[i-1];
            last_sr[0] <= rd_valid && (stage == ST_LAST_IDX);
            part_sr[0] <= rd_valid && rd_cnt[0];
            for (int i = 1; i < LAT - 1; i++) begin
                last_sr[i] <= last_sr[i-1];
                part_sr[i] <= part_sr[i-1];
            end
            st_zero_q  <= rd_valid && (stage == '0);
            sector_q   <= sec_raw;
            w_addr_q   <= w_next;
        end
    end

    assign bus.busy                  = busy_q;
    assign bus.done                  = done_q;
    assign bus.rd_addr               = rd_cnt;
    assign bus.stage                 = stage;
    assign bus.we                    = we_sr[LAT-1];
    assign bus.wr_addr               = wa_sr[LAT-1];
    assign bus.st_last               = last_sr[LAT-2];
    assign bus.second_part_subsector = part_sr[LAT-2];
    assign bus.st_zero               = st_zero_q;
    assign bus.sector                = sector_q;
    assign bus.w_addr                = w_addr_q;
endmodule

// File: tb/tb_fht_stage_ctrl.sv
// Bench for fht_stage_ctrl at A_BIT=3, SEC_BIT=2, ST_BIT=4, LAT=5
// (8 words per bank, 5 stages of 13 cycles, 66 busy cycles).
module tb_fht_stage_ctrl;
    localparam int A_BIT    = 3;
    localparam int SEC_BIT  = 2;
    localparam int ST_BIT   = 4;
    localparam int LAT      = 5;
    localparam int DEPTH    = 8;
    localparam int NST      = 5;
    localparam int PERIOD   = DEPTH + LAT;
    localparam int BUSY_LEN = NST * PERIOD + 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fht_stage_ctrl_if #(.A_BIT(A_BIT), .SEC_BIT(SEC_BIT), .ST_BIT(ST_BIT)) bus ();

    fht_stage_ctrl #(.A_BIT(A_BIT), .SEC_BIT(SEC_BIT), .ST_BIT(ST_BIT), .LAT(LAT)) dut (
        .iCLK   (clk),
        .iRESET (rst_n),
        .bus    (bus)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input int t, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0d got=%0h want=%0h", name, t, act, exp);
        end
    endtask

    // Expected outputs as a closed-form function of the offset from the first READ cycle.
    typedef struct {
        logic       busy, done, we, st_zero, st_last, part;
        logic [2:0] rd_addr;
        logic [3:0] stage;
        logic [1:0] sector, w_addr;
    } exp_t;

    function automatic void read_at(input int u, output logic v, output int addr, output int stg);
        if (u < 0) begin
            v = 1'b0; addr = 0; stg = 0;
        end else if (u >= NST * PERIOD) begin
            v = 1'b0; addr = DEPTH - 1; stg = NST - 1;
        end else begin
            stg  = u / PERIOD;
            v    = (u % PERIOD) < DEPTH;
            addr = v ? (u % PERIOD) : DEPTH - 1;
        end
    endfunction

    function automatic exp_t expect_at(input int t);
        exp_t e;
        logic v0, v1, v4, v5;
        int a0, a1, a4, a5, s0, s1, s4, s5, mm;
        read_at(t, v0, a0, s0);
        read_at(t - 1, v1, a1, s1);
        read_at(t - (LAT - 1), v4, a4, s4);
        read_at(t - LAT, v5, a5, s5);
        mm        = (s1 < A_BIT - 1) ? s1 : A_BIT - 1;
        e.busy    = (t < BUSY_LEN);
        e.done    = (t == BUSY_LEN - 1);
        e.rd_addr = 3'(a0);
        e.stage   = 4'(s0);
        e.st_zero = v1 && (s1 == 0);
        e.sector  = 2'(a1 >> (A_BIT - SEC_BIT));
        e.w_addr  = 2'(((a1 >> 1) << (A_BIT - 1 - mm)) & 3);
        e.st_last = v4 && (s4 == NST - 1);
        e.part    = v4 && (a4 % 2 == 1);
        e.we      = v5;
        return e;
    endfunction

    // Scoreboard of writes owed: pushed when a read is issued, popped when oWE appears.
    typedef struct { int addr; int due; } wr_exp_t;
    wr_exp_t wr_q[$];
    int      wr_seen;

    // Captured outputs of the first transform for the hand-written vector table.
    typedef struct {
        logic       busy, done, we, st_zero, st_last, part;
        logic [2:0] rd_addr, wr_addr;
        logic [3:0] stage;
        logic [1:0] w_addr;
    } obs_t;
    obs_t obs [80];
    bit   capture = 1'b0;
    int   busy_cnt, done_cnt;

    task automatic compare_cycle(input int t);
        exp_t    e;
        wr_exp_t w;
        logic    v;
        int      a, s;
        e = expect_at(t);
        check("busy",    t, bus.busy,    e.busy);
        check("done",    t, bus.done,    e.done);
        check("rd_addr", t, bus.rd_addr, e.rd_addr);
        check("stage",   t, bus.stage,   e.stage);
        check("we",      t, bus.we,      e.we);
        check("st_zero", t, bus.st_zero, e.st_zero);
        check("st_last", t, bus.st_last, e.st_last);
        check("part2",   t, bus.second_part_subsector, e.part);
        if (t >= 1) begin
            check("sector", t, bus.sector, e.sector);
            check("w_addr", t, bus.w_addr, e.w_addr);
        end
        read_at(t, v, a, s);
        if (v) wr_q.push_back('{addr: a, due: t + LAT});
        if (bus.we === 1'b1) begin
            wr_seen++;
            if (wr_q.size() == 0) begin
                check("wr_unexpected", t, 1, 0);
            end else begin
                w = wr_q.pop_front();
                check("wr_addr", t, bus.wr_addr, w.addr);
                check("wr_time", t, t, w.due);
            end
        end
        busy_cnt += int'(bus.busy === 1'b1);
        done_cnt += int'(bus.done === 1'b1);
        if (capture && t < 80) begin
            obs[t] = '{busy: bus.busy, done: bus.done, we: bus.we, st_zero: bus.st_zero,
                       st_last: bus.st_last, part: bus.second_part_subsector,
                       rd_addr: bus.rd_addr, wr_addr: bus.wr_addr, stage: bus.stage,
                       w_addr: bus.w_addr};
        end
    endtask

    // Issue a one-cycle start pulse and check offsets 0..last_t.
    task automatic run_pulse(input int last_t);
        @(negedge clk);
        bus.start = 1'b1;
        for (int t = 0; t <= last_t; t++) begin
            @(negedge clk);
            compare_cycle(t);
            if (t == 0) bus.start = 1'b0;
        end
    endtask

    typedef enum {F_BUSY, F_DONE, F_RD, F_WE, F_WR, F_ZERO, F_LAST, F_PART, F_WADDR, F_STAGE} fld_e;
    typedef struct { int t; fld_e f; int val; } vec_t;
    vec_t vecs[$];

    function automatic int obs_field(input int t, input fld_e f);
        case (f)
            F_BUSY:  return int'(obs[t].busy);
            F_DONE:  return int'(obs[t].done);
            F_RD:    return int'(obs[t].rd_addr);
            F_WE:    return int'(obs[t].we);
            F_WR:    return int'(obs[t].wr_addr);
            F_ZERO:  return int'(obs[t].st_zero);
            F_LAST:  return int'(obs[t].st_last);
            F_PART:  return int'(obs[t].part);
            F_WADDR: return int'(obs[t].w_addr);
            default: return int'(obs[t].stage);
        endcase
    endfunction

    initial begin
        // Hand-derived points of the first transform: {offset from first READ, output, value}.
        vecs.push_back('{0,  F_BUSY,  1}); vecs.push_back('{0,  F_RD,    0});
        vecs.push_back('{3,  F_RD,    3}); vecs.push_back('{7,  F_RD,    7});
        vecs.push_back('{10, F_RD,    7}); vecs.push_back('{4,  F_WE,    0});
        vecs.push_back('{5,  F_WE,    1}); vecs.push_back('{5,  F_WR,    0});
        vecs.push_back('{12, F_WE,    1}); vecs.push_back('{12, F_WR,    7});
        vecs.push_back('{13, F_WE,    0}); vecs.push_back('{0,  F_ZERO,  0});
        vecs.push_back('{1,  F_ZERO,  1}); vecs.push_back('{8,  F_ZERO,  1});
        vecs.push_back('{9,  F_ZERO,  0}); vecs.push_back('{4,  F_PART,  0});
        vecs.push_back('{5,  F_PART,  1}); vecs.push_back('{6,  F_PART,  0});
        vecs.push_back('{11, F_PART,  1}); vecs.push_back('{12, F_PART,  0});
        vecs.push_back('{7,  F_WADDR, 0}); vecs.push_back('{20, F_WADDR, 2});
        vecs.push_back('{20, F_STAGE, 1}); vecs.push_back('{52, F_STAGE, 4});
        vecs.push_back('{55, F_LAST,  0}); vecs.push_back('{56, F_LAST,  1});
        vecs.push_back('{63, F_LAST,  1}); vecs.push_back('{64, F_LAST,  0});
        vecs.push_back('{64, F_DONE,  0}); vecs.push_back('{65, F_DONE,  1});
        vecs.push_back('{65, F_BUSY,  1}); vecs.push_back('{66, F_BUSY,  0});
        vecs.push_back('{66, F_DONE,  0});

        bus.start = 1'b0;
        rst_n     = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy",    -1, bus.busy,    0);
        check("rst_done",    -1, bus.done,    0);
        check("rst_we",      -1, bus.we,      0);
        check("rst_rd_addr", -1, bus.rd_addr, 0);
        check("rst_stage",   -1, bus.stage,   0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Full transform from a single start pulse.
        wr_q.delete(); wr_seen = 0; busy_cnt = 0; done_cnt = 0;
        capture = 1'b1;
        run_pulse(75);
        capture = 1'b0;
        check("busy_len",   0, busy_cnt, BUSY_LEN);
        check("done_count", 0, done_cnt, 1);
        check("wr_total",   0, wr_seen,  NST * DEPTH);
        check("wr_pending", 0, wr_q.size(), 0);
        foreach (vecs[i]) check($sformatf("vec%0d", i), vecs[i].t, obs_field(vecs[i].t, vecs[i].f), vecs[i].val);

        // Reset in the middle of stage 2, held low for one cycle.
        run_pulse(2 * PERIOD + 3);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("arst_busy",    0, bus.busy,    0);
        check("arst_we",      0, bus.we,      0);
        check("arst_rd_addr", 0, bus.rd_addr, 0);
        check("arst_stage",   0, bus.stage,   0);
        check("arst_st_zero", 0, bus.st_zero, 0);
        check("arst_part2",   0, bus.second_part_subsector, 0);
        check("arst_w_addr",  0, bus.w_addr,  0);
        check("arst_sector",  0, bus.sector,  0);
        @(negedge clk);
        rst_n = 1'b1;
        wr_q.delete();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("post_rst_we",   i, bus.we,   0);
            check("post_rst_done", i, bus.done, 0);
            check("post_rst_busy", i, bus.busy, 0);
        end
        wr_seen = 0; busy_cnt = 0; done_cnt = 0;
        run_pulse(70);
        check("restart_busy_len", 0, busy_cnt, BUSY_LEN);
        check("restart_done",     0, done_cnt, 1);
        check("restart_wr_total", 0, wr_seen,  NST * DEPTH);

        // Start held high: one idle cycle between back-to-back transforms.
        wr_q.delete(); wr_seen = 0; busy_cnt = 0; done_cnt = 0;
        @(negedge clk);
        bus.start = 1'b1;
        for (int t = 0; t <= BUSY_LEN; t++) begin
            @(negedge clk);
            compare_cycle(t);
        end
        for (int t = 0; t <= BUSY_LEN + 4; t++) begin
            @(negedge clk);
            compare_cycle(t);
            if (t == BUSY_LEN - 1) bus.start = 1'b0;
        end
        check("held_busy_len", 0, busy_cnt, 2 * BUSY_LEN);
        check("held_done",     0, done_cnt, 2);
        check("held_wr_total", 0, wr_seen,  2 * NST * DEPTH);
        check("held_pending",  0, wr_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
